// File: rtl/varredura_teclado_if.sv
// Scan/handshake bundle between the keypad scanner, the keypad matrix and the key consumer.
// The master side is the scanner; the slave side is its environment.
interface varredura_teclado_if;
  logic       enable_i;
  logic       linha_i;
  logic       ack_i;
  logic [3:0] entrada_o;
  logic [3:0] tecla_o;
  logic       valida_o;

  modport master (input enable_i, linha_i, ack_i, output entrada_o, tecla_o, valida_o);
  modport slave  (output enable_i, linha_i, ack_i, input entrada_o, tecla_o, valida_o);
endinterface

// File: rtl/varredura_teclado.sv
// Keypad scan sequencer: walks the decoder index, debounces the shared return line
// and reports the pressed key code through a valid/ack handshake.
module varredura_teclado #(
  parameter int DIV      = 4,
  parameter int DEBOUNCE = 3
) (
  input  logic                clk,
  input  logic                rst_n,
  varredura_teclado_if.master bus
);
  localparam int            PW         = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(DIV - 1);
  localparam logic [3:0]    DEB        = 4'(DEBOUNCE);

  typedef enum logic [1:0] {SCAN, CONFIRM, HOLD, RELEASE} state_t;

  state_t        state_q, state_d;
  logic [PW-1:0] presc_q, presc_d;
  logic [1:0]    sync_q;
  logic [3:0]    entrada_q, entrada_d;
  logic [3:0]    tecla_q, tecla_d;
  logic [3:0]    cnt_q, cnt_d;
  logic [3:0]    rel_q, rel_d;
  logic          valida_q, valida_d;
  logic          tick;
  logic          s;

  assign tick = bus.enable_i && (presc_q == PRESC_LAST);
  assign s    = sync_q[1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= SCAN;
      presc_q   <= '0;
      sync_q    <= '0;
      entrada_q <= '0;
      tecla_q   <= '0;
      cnt_q     <= '0;
      rel_q     <= '0;
      valida_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      presc_q   <= presc_d;
      sync_q    <= {sync_q[0], bus.linha_i};
      entrada_q <= entrada_d;
      tecla_q   <= tecla_d;
      cnt_q     <= cnt_d;
      rel_q     <= rel_d;
      valida_q  <= valida_d;
    end
  end

  // The candidate key is the frozen scan index, so no separate candidate register is kept.
  always_comb begin
    state_d   = state_q;
    presc_d   = presc_q;
    entrada_d = entrada_q;
    tecla_d   = tecla_q;
    cnt_d     = cnt_q;
    rel_d     = rel_q;
    valida_d  = valida_q;

    if (bus.enable_i) begin
      presc_d = tick ? '0 : presc_q + PW'(1);
    end

    unique case (state_q)
      SCAN: begin
        if (tick) begin
          if (s) begin
            cnt_d = 4'd1;
            if (DEB == 4'd1) begin
              tecla_d  = entrada_q;
              valida_d = 1'b1;
              state_d  = HOLD;
            end else begin
              state_d = CONFIRM;
            end
          end else begin
            entrada_d = entrada_q + 4'd1;
          end
        end
      end
      CONFIRM: begin
        if (tick) begin
          if (s) begin
            cnt_d = cnt_q + 4'd1;
            if (cnt_q + 4'd1 == DEB) begin
              tecla_d  = entrada_q;
              valida_d = 1'b1;
              state_d  = HOLD;
            end
          end else begin
            entrada_d = entrada_q + 4'd1;
            state_d   = SCAN;
          end
        end
      end
      // Release debouncing only starts once the consumer has taken the code.
      HOLD: begin
        if (bus.ack_i) begin
          valida_d = 1'b0;
          rel_d    = '0;
          state_d  = RELEASE;
        end
      end
      RELEASE: begin
        if (tick) begin
          if (!s) begin
            rel_d = rel_q + 4'd1;
            if (rel_q + 4'd1 == DEB) begin
              entrada_d = entrada_q + 4'd1;
              state_d   = SCAN;
            end
          end else begin
            rel_d = '0;
          end
        end
      end
      default: state_d = SCAN;
    endcase
  end

  assign bus.entrada_o = entrada_q;
  assign bus.tecla_o   = tecla_q;
  assign bus.valida_o  = valida_q;
endmodule

// File: doc/varredura_teclado.md
# varredura_teclado

Keypad scan sequencer that sits directly upstream of the 4-to-16 line decoder. It generates the 4-bit scan index that the decoder turns into one-hot column selects, and samples the single shared return line. It debounces the return line and reports the code of the pressed key with a valid/ack handshake. The decoder and this block together form the 16-key keypad front end.

## Interface
- DIV, 4: clock cycles per scan step (prescaler period); legal range 3..256.
- DEBOUNCE, 3: consecutive agreeing samples needed to accept a press or a release; legal range 1..15.

- Clock  in  1  system clock; all state on the rising edge.
- Reset_n  in  1  asynchronous, active-low reset; one clock domain.
- Enable  in  1  high = scanning runs; low = prescaler and scan index frozen.
- Linha  in  1  asynchronous return line, active high; synchronised internally by 2 flip-flops.
- Entrada  out  4  scan index, driven straight into the decoder input.
- Tecla  out  4  code of the accepted key; valid while Valida is high.
- Valida  out  1  high = new key code available.
- Ack  in  1  consumer acknowledge; sampled only while Valida is high.

## Operation
- **Tick:** prescaler counts 0..DIV-1 while Enable is high. A tick is the cycle where prescaler == DIV-1 and Enable is high; the prescaler wraps to 0 there. All sampling and index changes happen only on ticks.
- **Sample:** s = synchronised Linha value at the tick.
- **SCAN:**
  - Tick with s=0: Entrada <= Entrada+1, modulo 16 (15 wraps to 0).
  - Tick with s=1: cand <= Entrada, cnt <= 1, go to CONFIRM. Entrada holds.
- **CONFIRM:** Entrada stays at cand.
  - Tick with s=1: cnt <= cnt+1.
  - When cnt reaches DEBOUNCE: Tecla <= cand, Valida <= 1, go to HOLD.
  - Tick with s=0: go to SCAN and Entrada <= cand+1, modulo 16.
  - With DEBOUNCE=1, the first high sample goes straight from SCAN to HOLD with Valida set.
- **HOLD:** Entrada stays at cand, Valida stays high.
  - Ack=1 in any cycle: Valida <= 0, rel <= 0, go to RELEASE.
  - Ticks are ignored for release counting while in HOLD.
- **RELEASE:** Entrada stays at cand.
  - Tick with s=0: rel <= rel+1.
  - Tick with s=1: rel <= 0.
  - When rel reaches DEBOUNCE: go to SCAN and Entrada <= cand+1.
- **Ack outside HOLD:** ignored.
- **Ack held high:** Valida is high for exactly 1 cycle once HOLD is reached.
- **No re-report:** a key held forever is reported once. Valida cannot reassert until RELEASE completes.
- **Enable low:** no ticks occur and the FSM state is kept. The Valida/Ack handshake still operates.
- **Reset values (async, immediate):** Entrada=0, Tecla=0, Valida=0, prescaler=0, cnt=0, rel=0, synchroniser=0, state=SCAN. Reset mid-operation discards any pending key.

## Timing
- Entrada changes only on the cycle after a tick, so each index is stable for DIV cycles.
- The synchroniser adds 2 cycles. DIV>=3 guarantees that the sample at a tick reflects the current Entrada.
- Press latency: Valida rises 1 cycle after the tick that gives the DEBOUNCE-th consecutive high sample. That is (DEBOUNCE-1)*DIV cycles after the detecting tick.
- Ack to Valida low: 1 cycle.
- Tecla is stable from the cycle Valida rises until the next accepted key.
- Idle full scan period: 16*DIV cycles.

## Test plan
- Reset: assert Reset_n=0 while in HOLD with Tecla=9 → Entrada=0, Tecla=0, Valida=0 immediately, with no clock edge needed. After release, idle scan restarts from index 0.
- Idle scan (DIV=4, Linha=0, Enable=1) → Entrada steps 0,1,…,15,0 every 4 cycles; wrap 15→0 occurs 64 cycles after leaving reset.
- Press key 9 (Linha = (Entrada==9), held, DEBOUNCE=3) → Entrada freezes at 9. Valida=1 with Tecla=9 exactly 8 cycles after the detecting tick plus 1. No second Valida while the key stays held.
- Bounce: Linha high for one tick only at index 5 → no Valida; Entrada steps to 6 on the next tick.
- Handshake/release: after the key-9 report, pulse Ack=1 for 1 cycle → Valida=0 on the next cycle. Drop Linha → after 3 low ticks Entrada=10. Ack pulses while Valida=0 have no effect.
- Enable: drop Enable for 20 cycles mid-scan at index 3 → Entrada holds 3 and no state change occurs. Re-enable → the prescaler resumes from its held count.
